// File: rtl/alu_operand_collector.sv
// Operand collector in front of the ALU: gathers OPA/OPB arriving on separate
// cycles, then issues one registered single-cycle request or a timeout error.
module alu_operand_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_ce,
    input  logic                  in_mode,
    input  logic [3:0]            in_cmd,
    input  logic                  in_cin,
    input  logic [DATA_WIDTH-1:0] in_opa,
    input  logic [DATA_WIDTH-1:0] in_opb,
    input  logic [1:0]            in_valid,
    output logic                  CE,
    output logic                  MODE,
    output logic [3:0]            CMD,
    output logic                  CIN,
    output logic [DATA_WIDTH-1:0] OPA,
    output logic [DATA_WIDTH-1:0] OPB,
    output logic [1:0]            INP_VALID,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic                  h_mode, h_cin;
    logic [3:0]            h_cmd;
    logic [DATA_WIDTH-1:0] h_op;
    logic                  hold_load, issue, tmo;
    logic                  iss_mode, iss_cin;
    logic [3:0]            iss_cmd;
    logic [DATA_WIDTH-1:0] iss_opa, iss_opb;
    logic [1:0]            iss_valid, need;

    // bit0 = command consumes A, bit1 = command consumes B
    function automatic logic [1:0] operand_need(input logic mode, input logic [3:0] cmd);
        operand_need = 2'b11;
        if (mode) begin
            case (cmd)
                4'd4, 4'd5: operand_need = 2'b01;
                4'd6, 4'd7: operand_need = 2'b10;
                default:    operand_need = 2'b11;
            endcase
        end else begin
            case (cmd)
                4'd6, 4'd8, 4'd9:   operand_need = 2'b01;
                4'd7, 4'd10, 4'd11: operand_need = 2'b10;
                default:            operand_need = 2'b11;
            endcase
        end
    endfunction

    assign need = operand_need(in_mode, in_cmd);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_nx  = state;
        cnt_nx    = cnt;
        hold_load = 1'b0;
        issue     = 1'b0;
        tmo       = 1'b0;
        iss_mode  = in_mode;
        iss_cmd   = in_cmd;
        iss_cin   = in_cin;
        iss_opa   = '0;
        iss_opb   = '0;
        iss_valid = 2'b00;

        case (state)
            IDLE: begin
                if (in_ce) begin
                    if ((in_valid & need) == need) begin
                        issue     = 1'b1;
                        iss_valid = need;
                        iss_opa   = need[0] ? in_opa : '0;
                        iss_opb   = need[1] ? in_opb : '0;
                    end else if (need == 2'b11 && in_valid != 2'b00) begin
                        hold_load = 1'b1;
                        cnt_nx    = '0;
                        state_nx  = in_valid[0] ? WAIT_B : WAIT_A;
                    end
                end
            end

            WAIT_A, WAIT_B: begin
                cnt_nx   = cnt + CW'(1);
                iss_mode = h_mode;
                iss_cmd  = h_cmd;
                iss_cin  = h_cin;
                if (in_ce && ((state == WAIT_A) ? in_valid[0] : in_valid[1])) begin
                    issue     = 1'b1;
                    iss_valid = 2'b11;
                    iss_opa   = (state == WAIT_A) ? in_opa : h_op;
                    iss_opb   = (state == WAIT_A) ? h_op : in_opb;
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                end else if (cnt == LAST_WAIT) begin
                    // Completion on the final edge wins; otherwise the held operand is dropped.
                    tmo      = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end

            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: the hold registers are reset too; they are small and this keeps
    // every flop deterministic out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_mode <= 1'b0;
            h_cmd  <= 4'd0;
            h_cin  <= 1'b0;
            h_op   <= '0;
        end else if (hold_load) begin
            h_mode <= in_mode;
            h_cmd  <= in_cmd;
            h_cin  <= in_cin;
            h_op   <= in_valid[0] ? in_opa : in_opb;
        end
    end

    // Issue fields only change on an issue; strobes are pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CE          <= 1'b0;
            INP_VALID   <= 2'b00;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            MODE        <= 1'b0;
            CMD         <= 4'd0;
            CIN         <= 1'b0;
            OPA         <= '0;
            OPB         <= '0;
        end else begin
            CE          <= issue;
            INP_VALID   <= iss_valid;
            timeout_err <= tmo;
            busy        <= (state_nx != IDLE);
            if (issue) begin
                MODE <= iss_mode;
                CMD  <= iss_cmd;
                CIN  <= iss_cin;
                OPA  <= iss_opa;
                OPB  <= iss_opb;
            end
        end
    end

endmodule
